glitch_wb_master: RTL and testbench
===================================

# glitch_wb_master

Wishbone initiator that turns a byte-wide command stream into single read/write cycles on the glitcher's register bus (`glitch_wb` and any peer slave with the same 4-bit word address / 8-bit data bus). It sits between a host-facing byte link (UART receiver/transmitter pair or similar) and the register bus. It returns exactly one response byte per command, and a bus timeout guarantees a hung slave cannot lock up the host.

## Interface
Parameters:
- `TIMEOUT`, default 16: cycles `stb_o` may stay high without `ack_i` before the cycle is abandoned; legal range 2..255.

Ports (name, direction, width, meaning):
- `clk_i`  in  1  single system clock.
- `rst_i`  in  1  reset; synchronous, active-low.
- `cmd_dat_i`  in  8  command/data byte from host link.
- `cmd_valid_i`  in  1  `cmd_dat_i` valid.
- `cmd_ready_o`  out  1  byte accepted when `cmd_valid_i & cmd_ready_o`.
- `rsp_dat_o`  out  8  response byte.
- `rsp_err_o`  out  1  response is a timeout error; qualified by `rsp_valid_o`.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  host consumes response.
- `adr_o`  out  [5:2]  Wishbone word address.
- `dat_o`  out  8  Wishbone write data.
- `dat_i`  in  8  Wishbone read data.
- `we_o`  out  1  Wishbone write enable.
- `stb_o`  out  1  Wishbone strobe (doubles as cycle indication).
- `ack_i`  in  1  Wishbone acknowledge.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- Command byte: bit7 = write (1) / read (0); bits 3:0 = `adr_o[5:2]`; bits 6:4 reserved, ignored.
- Write command: exactly one further byte follows, which is the write data. Read command: no further byte.
- FSM states: IDLE, GET_DATA, BUS, RESP.
  - IDLE: `cmd_ready_o`=1. On accept, latch address and `we`. Next state is GET_DATA if write, BUS if read.
  - GET_DATA: `cmd_ready_o`=1. On accept, latch `dat_o` and go to BUS.
  - BUS: `stb_o`=1, `adr_o`/`we_o`/`dat_o` stable, `cmd_ready_o`=0. When `ack_i`=1 is sampled: capture `dat_i` (read) or 8'h00 (write) into `rsp_dat_o`, set `rsp_err_o`=0, go to RESP. When the timeout counter reaches `TIMEOUT` without ack: `rsp_dat_o`=8'hEE, `rsp_err_o`=1, go to RESP.
  - RESP: `rsp_valid_o`=1, with data/err held stable. On `rsp_ready_i`, go to IDLE.
- `ack_i` outside BUS is ignored. `cmd_valid_i` outside IDLE/GET_DATA is not accepted; it is back-pressured, not dropped.
- Timeout counter: 8 bits, cleared on entering BUS, increments each BUS cycle without ack. An ack in the same cycle the count reaches `TIMEOUT` wins, so the response is a success.

## Timing
- Reset values: `cmd_ready_o`=0 during reset and 1 the first cycle after; `stb_o`=0; `we_o`=0; `adr_o`=0; `dat_o`=0; `rsp_dat_o`=0; `rsp_err_o`=0; `rsp_valid_o`=0; `busy_o`=0; state = IDLE.
- `stb_o` rises on the first edge after the final command byte is accepted. It falls on the edge after `ack_i` is sampled high, so it is never held for an extra cycle past ack.
- With a zero-wait slave (ack one cycle after `stb_o`), the read latency from command accept to `rsp_valid_o` is 3 cycles.
- `rsp_valid_o` rises on the edge that drops `stb_o`.
- Back-to-back: a new command can be accepted the cycle after the response handshake.
- Reset during any state: all outputs take their reset values on that edge. A partially received command is discarded, and any in-flight `stb_o` drops immediately.

## Structure
- Add to the shared `glitch_defs.v`: the command-bit define (`GLITCH_CMD_WRITE`, bit 7), the state encodings (using master-specific names so they do not clash with the glitcher core's IDLE/DELAY/WIDTH), and the `GLITCH_RSP_TIMEOUT` value 8'hEE.
- Register address defines are reused unchanged.
- Single module with no sub-module. The timeout counter is inline.

## Test plan
- After reset, read `GLITCH_STATUS` through a real `glitch_wb` -> `rsp_dat_o`=8'h01, `rsp_err_o`=0.
- Write `GLITCH_DELAY_0` 8'hAB, then read it back -> write response 8'h00, read response 8'hAB. Check `stb_o` is high for exactly the slave's ack latency + 1 cycles.
- Stub slave with `ack_i` tied to 0 -> `stb_o` high for exactly `TIMEOUT` cycles, then response 8'hEE with `rsp_err_o`=1, then the FSM is back in IDLE.
- Hold `rsp_ready_i` low for 10 cycles with the next command already valid -> response held stable, `cmd_ready_o`=0 throughout; the next command is accepted one cycle after the handshake.
- Assert reset (0) while `stb_o` is high and while in GET_DATA -> `stb_o` and `busy_o` are 0 the next cycle, no response is emitted, and the following read of `GLITCH_WIDTH` behaves normally.
- Ack arriving in the same cycle the count reaches `TIMEOUT` -> success response, `rsp_err_o`=0.

Source files
------------

// File: rtl/glitch_wb_master_pkg.sv
// Shared types and constants for the glitcher's byte-command Wishbone initiator.
// Command byte: bit7 selects write, bits 3:0 carry the word address.
package glitch_wb_master_pkg;

    typedef enum logic [1:0] {
        WBM_IDLE     = 2'd0,
        WBM_GET_DATA = 2'd1,
        WBM_BUS      = 2'd2,
        WBM_RESP     = 2'd3
    } wbm_state_e;

    localparam int          GLITCH_CMD_WRITE   = 7;
    localparam logic [7:0]  GLITCH_RSP_TIMEOUT = 8'hEE;
    localparam logic [7:0]  GLITCH_RSP_WR_OK   = 8'h00;

    function automatic logic cmd_is_write(input logic [7:0] b);
        return b[GLITCH_CMD_WRITE];
    endfunction

    function automatic logic [3:0] cmd_addr(input logic [7:0] b);
        return b[3:0];
    endfunction

endpackage

// File: rtl/glitch_wb_master.sv
// Byte-command to single-cycle Wishbone initiator with bus timeout.
// One response byte per command; a silent slave yields 8'hEE with err set.
module glitch_wb_master
    import glitch_wb_master_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] cmd_dat_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    output logic [7:0] rsp_dat_o,
    output logic       rsp_err_o,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [5:2] adr_o,
    output logic [7:0] dat_o,
    input  logic [7:0] dat_i,
    output logic       we_o,
    output logic       stb_o,
    input  logic       ack_i,
    output logic       busy_o
);

    // Last BUS cycle index before the cycle is abandoned.
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    wbm_state_e r_state;
    wbm_state_e w_state_nxt;

    logic [3:0] r_adr;
    logic [7:0] r_dat;
    logic       r_we;
    logic [7:0] r_cnt;
    logic [7:0] r_rsp_dat;
    logic       r_rsp_err;

    logic w_accept;
    logic w_timeout;
    logic w_in_cmd;

    assign w_in_cmd  = (r_state == WBM_IDLE) || (r_state == WBM_GET_DATA);
    assign w_accept  = cmd_valid_i && cmd_ready_o;
    assign w_timeout = !ack_i && (r_cnt == LIMIT);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            WBM_IDLE: begin
                if (w_accept) begin
                    if (cmd_is_write(cmd_dat_i)) begin
                        w_state_nxt = WBM_GET_DATA;
                    end else begin
                        w_state_nxt = WBM_BUS;
                    end
                end
            end
            WBM_GET_DATA: begin
                if (w_accept) begin
                    w_state_nxt = WBM_BUS;
                end
            end
            WBM_BUS: begin
                if (ack_i || w_timeout) begin
                    w_state_nxt = WBM_RESP;
                end
            end
            WBM_RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt = WBM_IDLE;
                end
            end
            default: w_state_nxt = WBM_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= WBM_IDLE;
            r_adr     <= 4'd0;
            r_dat     <= 8'd0;
            r_we      <= 1'b0;
            r_cnt     <= 8'd0;
            r_rsp_dat <= 8'd0;
            r_rsp_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == WBM_IDLE && w_accept) begin
                r_adr <= cmd_addr(cmd_dat_i);
                r_we  <= cmd_is_write(cmd_dat_i);
            end
            if (r_state == WBM_GET_DATA && w_accept) begin
                r_dat <= cmd_dat_i;
            end
            // Counter only runs in BUS, so it is zero on every BUS entry.
            if (r_state != WBM_BUS) begin
                r_cnt <= 8'd0;
            end else if (ack_i) begin
                r_rsp_dat <= r_we ? GLITCH_RSP_WR_OK : dat_i;
                r_rsp_err <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_dat <= GLITCH_RSP_TIMEOUT;
                r_rsp_err <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // Gating with rst_i keeps the link stalled while reset is held.
    assign cmd_ready_o = rst_i && w_in_cmd;
    assign stb_o       = (r_state == WBM_BUS);
    assign rsp_valid_o = (r_state == WBM_RESP);
    assign busy_o      = (r_state != WBM_IDLE);
    assign adr_o       = r_adr;
    assign dat_o       = r_dat;
    assign we_o        = r_we;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_glitch_wb_master.sv
// Scoreboard bench for glitch_wb_master against a stub register slave.
// Random commands and slave latencies, plus directed edge cases.
module tb_glitch_wb_master;
    localparam int TO = 16;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [7:0] cmd_dat_i = 8'd0;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic [7:0] rsp_dat_o;
    logic       rsp_err_o;
    logic       rsp_valid_o;
    logic       rsp_ready_i = 1'b0;
    logic [5:2] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i;
    logic       we_o;
    logic       stb_o;
    logic       ack_i;
    logic       busy_o;

    glitch_wb_master #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_dat_i(cmd_dat_i), .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o),
        .stb_o(stb_o), .ack_i(ack_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [3:0] A_STATUS = 4'h0;
    localparam logic [3:0] A_DELAY0 = 4'h1;
    localparam logic [3:0] A_WIDTH  = 4'h3;

    int passed = 0;
    int total  = 0;

    // Stub slave: acks after lat_cur cycles of strobe.
    logic [7:0] slv_mem [16];
    int         lat_cur = 1;
    int         slv_cnt = 0;
    assign ack_i = stb_o && (slv_cnt == lat_cur);
    assign dat_i = slv_mem[adr_o];

    always @(posedge clk_i) begin
        if (!stb_o || ack_i) slv_cnt <= 0;
        else slv_cnt <= slv_cnt + 1;
        if (stb_o && ack_i && we_o) slv_mem[adr_o] <= dat_o;
    end

    // Reference model: register contents plus expected responses.
    logic [7:0] ref_mem [16];
    logic [8:0] exp_q [$];
    int         len_q [$];
    int         rdy_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            case (rdy_mode)
                1: rsp_ready_i = 1'b0;
                2: rsp_ready_i = 1'b1;
                default: rsp_ready_i = ($urandom % 4) != 0;
            endcase
        end
    end

    int stb_run = 0;
    always @(negedge clk_i) begin
        if (!rst_i) begin
            stb_run = 0;
        end else begin
            if (stb_o) begin
                stb_run++;
            end else if (stb_run != 0) begin
                if (len_q.size() == 0) chk("stb_len_unexp", 1, 0);
                else chk("stb_len", stb_run, len_q.pop_front());
                stb_run = 0;
            end
            if (rsp_valid_o && rsp_ready_i) begin
                if (exp_q.size() == 0) chk("rsp_unexp", 1, 0);
                else chk("rsp", {rsp_err_o, rsp_dat_o}, exp_q.pop_front());
            end
        end
    end

    function automatic logic [8:0] model(input logic we, input logic [3:0] a,
                                         input logic [7:0] d, input int lat);
        if (lat >= TO) return {1'b1, 8'hEE};
        if (we) begin
            ref_mem[a] = d;
            return 9'h000;
        end
        return {1'b0, ref_mem[a]};
    endfunction

    function automatic int stb_len(input int lat);
        return (lat < TO) ? lat + 1 : TO;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        cmd_dat_i = b;
        cmd_valid_i = 1'b1;
        @(negedge clk_i);
        while (!cmd_ready_o && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        if (!cmd_ready_o) chk("send_timeout", 1, 0);
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk_i);
        while (busy_o && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        if (busy_o) chk("idle_timeout", 1, 0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_cmd(input logic we, input logic [3:0] a,
                          input logic [7:0] d, input int lat);
        wait_idle();
        lat_cur = lat;
        if (we) send_byte({1'b1, 3'($urandom), a});
        exp_q.push_back(model(we, a, d, lat));
        len_q.push_back(stb_len(lat));
        send_byte(we ? d : {1'b0, 3'($urandom), a});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        wait_idle();
    endtask

    task automatic pulse_reset();
        rst_i = 1'b0;
        exp_q.delete();
        len_q.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_stb", stb_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_rspv", rsp_valid_o, 0);
    endtask

    initial begin
        logic [7:0] d0;
        int n;
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        slv_mem[A_STATUS] = 8'h01;
        ref_mem[A_STATUS] = 8'h01;

        @(negedge clk_i);
        chk("rst_cmd_ready", cmd_ready_o, 0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("post_rst_cmd_ready", cmd_ready_o, 1);
        chk("post_rst_outs",
            {stb_o, we_o, adr_o, dat_o, rsp_dat_o, rsp_err_o,
             rsp_valid_o, busy_o}, 0);

        do_cmd(1'b0, A_STATUS, 8'h00, 1);
        do_cmd(1'b1, A_DELAY0, 8'hAB, 1);
        do_cmd(1'b0, A_DELAY0, 8'h00, 2);
        drain();

        do_cmd(1'b0, A_WIDTH, 8'h00, 255);
        drain();
        @(negedge clk_i);
        chk("timeout_idle", {busy_o, cmd_ready_o}, 2'b01);
        do_cmd(1'b1, A_WIDTH, 8'h5C, TO - 1);
        do_cmd(1'b1, A_WIDTH, 8'h77, TO);
        do_cmd(1'b0, A_WIDTH, 8'h00, 0);
        drain();

        // Response held off while the next command waits.
        rdy_mode = 1;
        do_cmd(1'b0, A_DELAY0, 8'h00, 1);
        cmd_dat_i = {4'h0, A_WIDTH};
        cmd_valid_i = 1'b1;
        exp_q.push_back(model(1'b0, A_WIDTH, 8'h00, 1));
        len_q.push_back(stb_len(1));
        n = 0;
        @(negedge clk_i);
        while (!rsp_valid_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        d0 = rsp_dat_o;
        chk("bp_first_dat", d0, 8'hAB);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk("bp_hold", {rsp_valid_o, rsp_dat_o, cmd_ready_o},
                {1'b1, d0, 1'b0});
        end
        rdy_mode = 2;
        n = 0;
        @(negedge clk_i);
        while (!(rsp_valid_o && rsp_ready_i) && n < 10) begin
            @(negedge clk_i);
            n++;
        end
        @(negedge clk_i);
        chk("bp_ready_after", {cmd_ready_o, busy_o}, 2'b10);
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        chk("bp_accept_next", stb_o, 1);
        rdy_mode = 0;
        drain();

        // Reset while waiting for write data.
        wait_idle();
        send_byte({1'b1, 3'b000, A_WIDTH});
        chk("getdata_busy", busy_o, 1);
        pulse_reset();

        // Reset while the strobe is up.
        wait_idle();
        lat_cur = 255;
        send_byte({4'h0, A_WIDTH});
        @(negedge clk_i);
        chk("bus_stb", stb_o, 1);
        @(posedge clk_i);
        #1;
        pulse_reset();
        do_cmd(1'b0, A_WIDTH, 8'h00, 1);
        drain();

        for (int k = 0; k < 40; k++) begin
            int sel;
            int lat;
            sel = $urandom_range(0, 9);
            lat = (sel < 7) ? $urandom_range(0, 3) :
                  (sel == 7) ? TO - 1 : (sel == 8) ? TO : 255;
            do_cmd(1'($urandom), 4'($urandom), 8'($urandom), lat);
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
